// File: rtl/hamming_pkg.sv
// Shared Hamming code geometry helpers and mode encodings for the stream codec.
package hamming_pkg;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // Smallest p with 2^p >= dw + p + 1.
   function automatic int calc_pw(input int dw);
      int p;
      p = 0;
      for (int i = 30; i >= 1; i--)
         if ((1 << i) >= dw + i + 1) p = i;
      return p;
   endfunction

   function automatic bit is_pow2(input int k);
      return (k > 0) && ((k & (k - 1)) == 0);
   endfunction

   // 1-based code position of data bit idx; parity positions are skipped.
   function automatic int data_pos(input int idx);
      int pos;
      int n;
      pos = 0;
      n   = 0;
      for (int k = 1; k < 128; k++)
         if (!is_pow2(k)) begin
            if (n == idx) pos = k;
            n++;
         end
      return pos;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Hamming syndrome: XOR of the 1-based indices of all set code bits.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module hamming_syndrome #(
   parameter int CW = 15,
   parameter int PW = 4
) (
   input  logic [CW-1:0] code,
   output logic [PW-1:0] syn
);

   always_comb begin
      syn = '0;
      for (int k = 1; k <= CW; k++)
         if (code[k-1]) syn = syn ^ PW'(k);
   end

endmodule

// File: rtl/hamming_stream_codec.sv
// Per-word Hamming encoder/corrector on a valid/ready stream, with saturating statistics.
// Latency: 2 cycles input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: both stages hold while out_valid && !out_ready; in_ready follows that stall.
module hamming_stream_codec
   import hamming_pkg::*;
#(
   parameter int DW     = 11,
   parameter int SECDED = 0,
   parameter int CNTW   = 16,
   localparam int PW    = calc_pw(DW),
   localparam int CW    = DW + PW,
   localparam int IW    = CW + SECDED
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_mode,
   input  logic [IW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_mode,
   output logic [IW-1:0]   out_data,
   output logic            out_err,
   output logic            out_dbl,
   output logic [PW-1:0]   out_syn,
   input  logic            clr_cnt,
   output logic [CNTW-1:0] cnt_words,
   output logic [CNTW-1:0] cnt_corr,
   output logic [CNTW-1:0] cnt_uncorr
);

   typedef struct packed {
      logic          vld;
      logic          mode;
      logic          op;
      logic [PW-1:0] syn;
      logic [CW-1:0] word;
   } s1_t;

   s1_t           s1_q;
   logic          en;
   logic          dec;
   logic          hs;
   logic [CW-1:0] placed;
   logic [CW-1:0] syn_in;
   logic [PW-1:0] syn_c;
   logic          op_c;
   logic          in_range;
   logic          err_c;
   logic          dbl_c;
   logic          flip_c;
   logic [CW-1:0] code_c;
   logic [CW-1:0] fixed_c;
   logic [DW-1:0] data_c;
   logic [IW-1:0] res_c;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      placed = '0;
      for (int i = 0; i < DW; i++) placed[data_pos(i)-1] = in_data[i];
   end

   // Encode reuses the syndrome tree: with parity slots zero, the syndrome is the parity.
   assign syn_in = (in_mode == MODE_DEC) ? in_data[CW-1:0] : placed;

   hamming_syndrome #(.CW(CW), .PW(PW)) u_syn (
      .code (syn_in),
      .syn  (syn_c)
   );

   // Without the overall bit, any nonzero syndrome is treated as an odd-weight error.
   assign op_c = (SECDED != 0) ? (^in_data) : (syn_c != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
      end else if (en) begin
         s1_q.vld  <= in_valid;
         s1_q.mode <= in_mode;
         s1_q.op   <= op_c;
         s1_q.syn  <= syn_c;
         s1_q.word <= (in_mode == MODE_DEC) ? in_data[CW-1:0] : placed;
      end
   end

   assign dec      = (s1_q.mode == MODE_DEC);
   assign in_range = (int'(s1_q.syn) <= CW);

   always_comb begin
      err_c  = 1'b0;
      dbl_c  = 1'b0;
      flip_c = 1'b0;
      if (s1_q.syn == '0) begin
         err_c = s1_q.op;
      end else if (s1_q.op && in_range) begin
         flip_c = 1'b1;
         err_c  = 1'b1;
      end else begin
         dbl_c = 1'b1;
      end
   end

   always_comb begin
      code_c = s1_q.word;
      for (int j = 0; j < PW; j++) code_c[(1 << j) - 1] = s1_q.syn[j];
      fixed_c = s1_q.word;
      for (int k = 1; k <= CW; k++)
         if (flip_c && (s1_q.syn == PW'(k))) fixed_c[k-1] = ~fixed_c[k-1];
      data_c = '0;
      for (int i = 0; i < DW; i++) data_c[i] = fixed_c[data_pos(i)-1];
      if (dec) begin
         res_c = IW'(data_c);
      end else begin
         res_c = IW'(code_c);
         if (SECDED != 0) res_c[IW-1] = ^code_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_mode  <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         out_dbl   <= 1'b0;
         out_syn   <= '0;
      end else if (en) begin
         out_valid <= s1_q.vld;
         out_mode  <= s1_q.mode;
         out_data  <= res_c;
         out_err   <= dec && err_c;
         out_dbl   <= dec && dbl_c;
         out_syn   <= dec ? s1_q.syn : '0;
      end
   end

   assign hs = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset || clr_cnt) begin
         cnt_words  <= '0;
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (hs) begin
         if (cnt_words != '1) cnt_words <= cnt_words + CNTW'(1);
         if ((out_mode == MODE_DEC) && out_err && (cnt_corr != '1))
            cnt_corr <= cnt_corr + CNTW'(1);
         if ((out_mode == MODE_DEC) && out_dbl && (cnt_uncorr != '1))
            cnt_uncorr <= cnt_uncorr + CNTW'(1);
      end
   end

endmodule
